// File: rtl/mem_access_arbiter.sv
// Purpose : shares one byte-wide single-port memory between the instruction-fetch
//           port (read-only, big-endian words) and the data port (read/write,
//           little-endian words).
// Latency : request seen in IDLE at edge k -> four byte cycles k+1..k+4 -> ready in k+5.
// Backpr. : no ready/valid stall; a requester holds req until its one-cycle ready
//           pulse, and the losing port simply waits for the next IDLE.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants between ports on
// simultaneous requests; otherwise the data port always wins.
//
// Ports:
//   clk, rst          clock (rising edge) and synchronous active-low reset
//   i_req/i_addr      fetch request and byte address
//   i_ready/i_rdata   fetch-complete pulse and word (byte at i_addr in the MSBs)
//   d_req/d_we/d_addr/d_wdata   data request, write flag, byte address, write word
//   d_ready/d_rdata   data-complete pulse and read word (byte at d_addr in the LSBs)
//   mem_addr/mem_wdata/mem_w_en/mem_r_en/mem_rdata   byte memory interface
//   busy              high while a transfer is in flight (XFER and DONE)
module mem_access_arbiter #(
    parameter int BIT_NUMBER = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_ready,
    output logic [4*BIT_NUMBER-1:0] i_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [4*BIT_NUMBER-1:0] d_wdata,
    output logic                    d_ready,
    output logic [4*BIT_NUMBER-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [BIT_NUMBER-1:0]   mem_wdata,
    output logic                    mem_w_en,
    output logic                    mem_r_en,
    input  logic [BIT_NUMBER-1:0]   mem_rdata,
    output logic                    busy
);

    localparam int WORD_W = 4 * BIT_NUMBER;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        cnt;        // byte index within the current word
    logic              owner_d;    // 1: data port owns the transfer, 0: instruction port
    logic              xfer_we;    // latched write flag (never set for instruction port)
    logic [WORD_W-1:0] wr_shift;   // write bytes still to be sent, next one in the LSBs
    logic [WORD_W-1:0] asm_q;      // read word being assembled
    logic [WORD_W-1:0] asm_next;   // asm_q with the current memory byte merged in
    logic [1:0]        slot;       // word byte position receiving the current byte
    logic              grant_d;    // arbitration result: 1 = data port wins

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;                  // 1: data port was granted last

    // On a tie the port that was not granted last wins.
    assign grant_d = d_req && !(i_req && last_d);
`else
    assign grant_d = d_req;
`endif

    // Data words are little-endian (byte cnt lands in slot cnt); instruction
    // words are big-endian (byte cnt lands in slot 3-cnt, i.e. ~cnt).
    always_comb begin
        slot     = owner_d ? cnt : ~cnt;
        asm_next = asm_q;
        for (int b = 0; b < 4; b++) begin
            if (slot == 2'(b)) begin
                asm_next[b*BIT_NUMBER +: BIT_NUMBER] = mem_rdata;
            end
        end
    end

    // Single FSM process; every output, including the memory strobes, is a
    // register so there is no path from any input to any output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            owner_d   <= 1'b0;
            xfer_we   <= 1'b0;
            wr_shift  <= '0;
            asm_q     <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_w_en  <= 1'b0;
            mem_r_en  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state   <= XFER;
                        cnt     <= 2'd0;
                        busy    <= 1'b1;
                        owner_d <= grant_d;
                        // Byte 0 is presented straight from the grant edge so
                        // the four byte cycles are exactly the four XFER cycles.
                        if (grant_d) begin
                            xfer_we   <= d_we;
                            mem_addr  <= d_addr;
                            mem_w_en  <= d_we;
                            mem_r_en  <= !d_we;
                            mem_wdata <= d_we ? d_wdata[BIT_NUMBER-1:0] : '0;
                            wr_shift  <= d_we ? (d_wdata >> BIT_NUMBER) : '0;
                        end else begin
                            xfer_we   <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_w_en  <= 1'b0;
                            mem_r_en  <= 1'b1;
                            mem_wdata <= '0;
                            wr_shift  <= '0;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_d <= grant_d;
`endif
                    end
                end

                XFER: begin
                    if (!xfer_we) begin
                        asm_q <= asm_next;
                    end
                    if (cnt == 2'd3) begin
                        state     <= DONE;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_w_en  <= 1'b0;
                        mem_r_en  <= 1'b0;
                        if (owner_d) begin
                            d_ready <= 1'b1;
                            // A write leaves the previous read word visible.
                            if (!xfer_we) begin
                                d_rdata <= asm_next;
                            end
                        end else begin
                            i_ready <= 1'b1;
                            i_rdata <= asm_next;
                        end
                    end else begin
                        cnt       <= cnt + 2'd1;
                        // Plain binary increment gives the wrap past the top
                        // of the address space for free.
                        mem_addr  <= mem_addr + ADDR_WIDTH'(1);
                        mem_wdata <= wr_shift[BIT_NUMBER-1:0];
                        wr_shift  <= wr_shift >> BIT_NUMBER;
                    end
                end

                DONE: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Purpose : self-checking bench for mem_access_arbiter with a byte memory model.
// Latency : checks the five-cycle request-to-ready timing and grant spacing.
// Backpr. : requesters hold req until ready, then drop it (or hold it to re-request).
module tb_mem_access_arbiter;

    localparam int BN = 8;
    localparam int AW = 32;
    localparam int WW = 4 * BN;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic [3:0] EXP_ORDER = 4'b1010;  // D,I,D,I (bit set = instruction)
`else
    localparam logic [3:0] EXP_ORDER = 4'b0000;  // D,D,D,D
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ready;
    logic [WW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [WW-1:0] d_wdata = '0;
    logic          d_ready;
    logic [WW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic [BN-1:0] mem_wdata;
    logic          mem_w_en;
    logic          mem_r_en;
    logic [BN-1:0] mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    mem_access_arbiter #(.BIT_NUMBER(BN), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w_en(mem_w_en),
        .mem_r_en(mem_r_en), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Byte memory: combinational read, write on the rising edge. Only the low
    // 12 address bits select a location; the model aliases the same way.
    logic [7:0] tb_mem [0:4095] = '{default: 8'h00};
    assign mem_rdata = tb_mem[mem_addr[11:0]];

    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic [31:0] wlog_addr [$];
    logic [7:0]  wlog_dat  [$];

    always @(posedge clk) begin
        if (mem_w_en) begin
            tb_mem[mem_addr[11:0]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
            wlog_addr.push_back(mem_addr);
            wlog_dat.push_back(mem_wdata);
        end
        if (mem_r_en) rd_cnt <= rd_cnt + 1;
    end

    // Reference model state
    logic [7:0]  ref_mem [0:4095] = '{default: 8'h00};
    logic [31:0] ref_i = '0;
    logic [31:0] ref_d = '0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Word at byte address a: data port weights byte j by 256^j, instruction
    // port weights byte j by 256^(3-j).
    function automatic logic [31:0] ref_word(input bit instr, input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] b;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            b = a + 32'(j);
            if (instr) w = w | (32'(ref_mem[b[11:0]]) << (8 * (3 - j)));
            else       w = w | (32'(ref_mem[b[11:0]]) << (8 * j));
        end
        return w;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] b;
        for (int j = 0; j < 4; j++) begin
            b = a + 32'(j);
            ref_mem[b[11:0]] = 8'((wd >> (8 * j)) & 32'hFF);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_i_ready"},   64'(i_ready),   64'd0);
        chk({tag, "_d_ready"},   64'(d_ready),   64'd0);
        chk({tag, "_i_rdata"},   64'(i_rdata),   64'd0);
        chk({tag, "_d_rdata"},   64'(d_rdata),   64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_mem_w_en"},  64'(mem_w_en),  64'd0);
        chk({tag, "_mem_r_en"},  64'(mem_r_en),  64'd0);
        chk({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    endtask

    // One access on one port, starting from IDLE at a sample point. Inputs
    // are scrambled after the grant to show they are ignored.
    task automatic do_txn(input bit instr, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
        int cyc;
        bit seen;
        bit other;
        bit busy_ok;
        int rd0;
        int wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        if (instr) begin
            i_req = 1'b1; i_addr = a;
            ref_i = ref_word(1'b1, a);
        end else begin
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
            if (we) ref_write(a, wd);
            else    ref_d = ref_word(1'b0, a);
        end
        cyc = 0; seen = 0; other = 0; busy_ok = 1;
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (!busy) busy_ok = 0;
            seen = instr ? i_ready : d_ready;
            if (instr ? d_ready : i_ready) other = 1;
            if (!seen) begin
                if (instr) i_addr = $urandom();
                else begin d_addr = $urandom(); d_wdata = $urandom(); d_we = 1'($urandom()); end
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        chk({tag, "_latency"},     64'(cyc),           64'd5);
        chk({tag, "_busy"},        64'(busy_ok),       64'd1);
        chk({tag, "_other_ready"}, 64'(other),         64'd0);
        chk({tag, "_i_rdata"},     64'(i_rdata),       64'(ref_i));
        chk({tag, "_d_rdata"},     64'(d_rdata),       64'(ref_d));
        chk({tag, "_rd_strobes"},  64'(rd_cnt - rd0),  (!instr && we) ? 64'd0 : 64'd4);
        chk({tag, "_wr_strobes"},  64'(wr_cnt - wr0),  (!instr && we) ? 64'd4 : 64'd0);
        @(posedge clk); #1;
        chk({tag, "_pulse"},       64'(i_ready | d_ready), 64'd0);
        chk({tag, "_busy_end"},    64'(busy),          64'd0);
    endtask

    typedef struct {
        bit          instr;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;   // expected rdata of the issuing port afterwards
    } vec_t;

    vec_t vecs [12];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d checks done", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int          wlen;
        bit          saw_ready;
        int          d_at;
        int          i_at;
        int          nseen;
        logic [3:0]  order;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
        bit          ins;
        bit          wr;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_00E0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'hE000_0000};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h1122_3344, 32'h0000_0000};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0404, 32'hC000_0000, 32'h0000_0000};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0404, 32'h0,         32'hC000_0000};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         32'h4433_2211};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0400, 32'h0,         32'h1122_3344};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0402, 32'h0,         32'h2211_0000};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_03FF, 32'h0,         32'h2233_4400};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0401, 32'hDEAD_BEEF, 32'h2233_4400};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0400, 32'h0,         32'hADBE_EF44};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0403, 32'h0,         32'hADDE_0000};

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i].instr, vecs[i].we, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_rdata", i),
                vecs[i].instr ? 64'(i_rdata) : 64'(d_rdata), 64'(vecs[i].exp));
            if (i == 2) begin
                chk("mem_400", 64'(tb_mem[12'h400]), 64'h44);
                chk("mem_401", 64'(tb_mem[12'h401]), 64'h33);
                chk("mem_402", 64'(tb_mem[12'h402]), 64'h22);
                chk("mem_403", 64'(tb_mem[12'h403]), 64'h11);
            end
        end

        // Address wrap on a write
        wlen = wlog_addr.size();
        do_txn(1'b0, 1'b1, 32'hFFFF_FFFE, 32'hAABB_CCDD, "wrap");
        chk("wrap_nwrites", 64'(wlog_addr.size() - wlen), 64'd4);
        chk("wrap_a0", 64'(wlog_addr[wlen]),   64'hFFFF_FFFE);
        chk("wrap_a1", 64'(wlog_addr[wlen+1]), 64'hFFFF_FFFF);
        chk("wrap_a2", 64'(wlog_addr[wlen+2]), 64'h0000_0000);
        chk("wrap_a3", 64'(wlog_addr[wlen+3]), 64'h0000_0001);
        chk("wrap_d0", 64'(wlog_dat[wlen]),    64'hDD);
        chk("wrap_d1", 64'(wlog_dat[wlen+1]),  64'hCC);
        chk("wrap_d2", 64'(wlog_dat[wlen+2]),  64'hBB);
        chk("wrap_d3", 64'(wlog_dat[wlen+3]),  64'hAA);

        // Reset sampled on the edge that writes the second byte
        wlen = wlog_addr.size();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'hFFFF_FFFE; d_wdata = 32'h5566_7788;
        saw_ready = 0;
        @(posedge clk); #1;            // grant
        @(posedge clk); #1;            // byte 0 written
        rst = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;            // byte 1 written, reset taken
        if (d_ready) saw_ready = 1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        if (d_ready) saw_ready = 1;
        rst = 1'b1;
        @(posedge clk); #1;
        if (d_ready) saw_ready = 1;
        chk("midrst_no_ready", 64'(saw_ready), 64'd0);
        chk("midrst_nwrites", 64'(wlog_addr.size() - wlen), 64'd2);
        chk("midrst_mem_ffe", 64'(tb_mem[12'hFFE]), 64'h88);
        chk("midrst_mem_fff", 64'(tb_mem[12'hFFF]), 64'h77);
        chk("midrst_mem_000", 64'(tb_mem[12'h000]), 64'hBB);
        chk("midrst_mem_001", 64'(tb_mem[12'h001]), 64'hAA);
        ref_mem[12'hFFE] = 8'h88;
        ref_mem[12'hFFF] = 8'h77;
        ref_i = '0;
        ref_d = '0;
        do_txn(1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0, "post_rst");
        chk("post_rst_word", 64'(d_rdata), 64'hAABB_7788);

        // Simultaneous requests straight after reset
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        ref_i = '0; ref_d = '0;
        i_req = 1'b1; i_addr = 32'h400; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h404;
        exp_d = ref_word(1'b0, 32'h404);
        exp_i = ref_word(1'b1, 32'h400);
        d_at = -1; i_at = -1;
        for (int c = 1; c <= 40 && i_at < 0; c++) begin
            @(posedge clk); #1;
            if (d_ready && d_at < 0) begin d_at = c; d_req = 1'b0; end
            if (i_ready && i_at < 0) begin i_at = c; i_req = 1'b0; end
        end
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        chk("tie_d_cycle", 64'(d_at), 64'd5);
        chk("tie_i_cycle", 64'(i_at), 64'd11);
        chk("tie_d_rdata", 64'(d_rdata), 64'(exp_d));
        chk("tie_i_rdata", 64'(i_rdata), 64'(exp_i));
        ref_d = exp_d; ref_i = exp_i;

        // Both ports held for four grants
        i_req = 1'b1; i_addr = 32'h404; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        order = '0; nseen = 0;
        for (int c = 1; c <= 60 && nseen < 4; c++) begin
            @(posedge clk); #1;
            if (i_ready || d_ready) begin
                chk($sformatf("held_time%0d", nseen), 64'(c), 64'(6 * nseen + 5));
                order[nseen[1:0]] = i_ready;
                nseen++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        chk("held_grants", 64'(nseen), 64'd4);
        chk("held_order", 64'(order), 64'(EXP_ORDER));
        ref_d = ref_word(1'b0, 32'h400);
        if (EXP_ORDER[1]) ref_i = ref_word(1'b1, 32'h404);
        chk("held_d_rdata", 64'(d_rdata), 64'(ref_d));
        chk("held_i_rdata", 64'(i_rdata), 64'(ref_i));

        // Random traffic against the reference model
        for (int t = 0; t < 150; t++) begin
            ins = 1'($urandom_range(0, 1));
            wr  = ins ? 1'b0 : 1'($urandom_range(0, 1));
            do_txn(ins, wr, $urandom(), $urandom(), $sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
